// File: rtl/risc_pkg.sv
// Shared definitions for the instruction issue path: opcode constants,
// the issue FSM state encoding and a helper that extracts an opcode.
package risc_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_AND    = 4'b0100;
    localparam logic [3:0] OP_OR     = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_MINALL = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2
    } issue_state_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Instruction FIFO: DEPTH x 16-bit storage, wrapping read/write pointers
// and an occupancy counter. Flush empties the queue in one cycle.
module ins_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [15:0]              wdata,
    output logic [15:0]              rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;

    // Storage write; pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == LW'(DEPTH));
    assign level = count_q;

endmodule

// File: rtl/ins_issue_ctrl.sv
// Instruction issue controller: queues instruction words and hands them to
// the core one at a time (IDLE -> ISSUE -> EXEC). A flush (taken branch)
// drops queued words but never the one in flight.
// Optional watchdog on EXEC enabled by macro INS_WDOG_EN.
//
// Handshake: a word is accepted on a cycle where in_valid && in_ready;
// in_ready = !full && !flush, with no same-cycle pass-through when full.
module ins_issue_ctrl
    import risc_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] WDOG_MAX = 8'd255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [15:0]            in_word,
    output logic                   in_ready,
    input  logic                   core_wait,
    input  logic                   flush,
    output logic                   new_ins,
    output logic [3:0]             ins,
    output logic [15:0]            ins_word,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   wdog_err,
    output issue_state_t           dbg_state
);

    issue_state_t state_q;
    logic         new_ins_q;
    logic [15:0]  ins_word_q;
    logic         busy_q;
    logic         seen_low_q;
    logic         fifo_full;
    logic [15:0]  head_word;
    logic         push;
    logic         issue;

    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;
    assign issue    = (state_q == ST_IDLE) && (level != '0) && core_wait && !flush;

    ins_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .flush (flush),
        .wdata (in_word),
        .rdata (head_word),
        .full  (fifo_full),
        .level (level)
    );

`ifdef INS_WDOG_EN
    logic [7:0] wdog_cnt_q;
    logic       wdog_err_q;
`else
    logic [7:0] unused_wdog_max;
    assign unused_wdog_max = WDOG_MAX;
`endif

    // Issue FSM with registered strobe/word/busy outputs (and watchdog).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            new_ins_q  <= 1'b0;
            ins_word_q <= '0;
            busy_q     <= 1'b0;
            seen_low_q <= 1'b0;
`ifdef INS_WDOG_EN
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
            new_ins_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q    <= ST_ISSUE;
                        new_ins_q  <= 1'b1;
                        ins_word_q <= head_word;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q    <= ST_EXEC;
                    seen_low_q <= 1'b0;
`ifdef INS_WDOG_EN
                    wdog_cnt_q <= '0;
`endif
                end
                ST_EXEC: begin
                    // Done only once core_wait has dropped and come back.
                    if (core_wait && seen_low_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (!core_wait) seen_low_q <= 1'b1;
`ifdef INS_WDOG_EN
                        wdog_cnt_q <= wdog_cnt_q + 8'd1;
                        if (wdog_cnt_q + 8'd1 == WDOG_MAX) begin
                            wdog_err_q <= 1'b1;
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign new_ins   = new_ins_q;
    assign ins_word  = ins_word_q;
    assign ins       = opcode_of(ins_word_q);
    assign busy      = busy_q;
    assign dbg_state = state_q;
`ifdef INS_WDOG_EN
    assign wdog_err  = wdog_err_q;
`else
    assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ins_issue_ctrl.sv
// Bench for ins_issue_ctrl: directed scenarios followed by random traffic,
// all cycles checked against a queue-based reference model.
module tb_ins_issue_ctrl;

    localparam int DEPTH = 4;
`ifdef INS_WDOG_EN
    localparam int  WDOG  = 10;
    localparam bit  WD_EN = 1'b1;
`else
    localparam int  WDOG  = 255;
    localparam bit  WD_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = '0;
    logic        in_ready;
    logic        core_wait = 1'b0;
    logic        flush = 1'b0;
    logic        new_ins;
    logic [3:0]  ins;
    logic [15:0] ins_word;
    logic [$clog2(DEPTH):0] level;
    logic        busy;
    logic        wdog_err;
    risc_pkg::issue_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    ins_issue_ctrl #(.DEPTH(DEPTH), .WDOG_MAX(8'(WDOG))) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (in_ready),
        .core_wait (core_wait),
        .flush     (flush),
        .new_ins   (new_ins),
        .ins       (ins),
        .ins_word  (ins_word),
        .level     (level),
        .busy      (busy),
        .wdog_err  (wdog_err),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    // exp_q holds the queued words in issue order; m_phase: 0 idle,
    // 1 strobe cycle, 2 executing.
    logic [15:0] exp_q[$];
    bit          m_valid = 1'b0;
    int          m_phase;
    bit          m_new;
    logic [15:0] m_word;
    bit          m_seen_low;
    int          m_exec_cycles;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("new_ins",  new_ins,  m_new);
        check("ins",      ins,      m_word[15:12]);
        check("ins_word", ins_word, m_word);
        check("level",    level,    exp_q.size());
        check("busy",     busy,     m_phase != 0);
        check("idle",     dbg_state == risc_pkg::ST_IDLE, m_phase == 0);
        check("wdog_err", wdog_err, m_err);
    endtask

    task automatic model_step(input bit v, input logic [15:0] w, input bit cw,
                              input bit fl, input bit rst);
        bit do_push;
        bit do_issue;
        if (rst) begin
            exp_q.delete();
            m_valid = 1'b1;
            m_phase = 0;
            m_new = 1'b0;
            m_word = '0;
            m_seen_low = 1'b0;
            m_exec_cycles = 0;
            m_err = 1'b0;
            return;
        end
        do_push  = v && (exp_q.size() < DEPTH) && !fl;
        do_issue = (m_phase == 0) && (exp_q.size() > 0) && cw && !fl;
        m_new = 1'b0;
        if (m_phase == 0) begin
            if (do_issue) begin
                m_word  = exp_q.pop_front();
                m_new   = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_seen_low = 1'b0;
            m_exec_cycles = 0;
        end else begin
            if (cw && m_seen_low) begin
                m_phase = 0;
            end else begin
                if (!cw) m_seen_low = 1'b1;
                m_exec_cycles++;
                if (WD_EN && m_exec_cycles == WDOG) begin
                    m_err = 1'b1;
                    m_phase = 0;
                end
            end
        end
        if (fl) exp_q.delete();
        if (do_push) exp_q.push_back(w);
    endtask

    // ---------------- driver ----------------
    // One clock cycle: check registered outputs, apply inputs, check the
    // combinational ready, then advance the model across the coming edge.
    task automatic cycle(input bit v, input logic [15:0] w, input bit cw,
                         input bit fl, input bit rst);
        @(negedge clock);
        if (m_valid) check_outputs();
        in_valid  = v;
        in_word   = w;
        core_wait = cw;
        flush     = fl;
        reset     = rst;
        #1;
        if (m_valid) check("in_ready", in_ready, (exp_q.size() < DEPTH) && !fl);
        model_step(v, w, cw, fl, rst);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Basic issue and minimum latency
        cycle(0, 16'h0, 1, 0, 1);
        cycle(0, 16'h0, 1, 0, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_new_ins", new_ins, 0);
        check("rst_ins_word", ins_word, 16'h0);
        cycle(1, 16'h2123, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        check("lat_level1", level, 1);
        cycle(0, 16'h0, 1, 0, 0);
        check("lat_new_ins", new_ins, 1);
        check("lat_ins", ins, 4'h2);
        check("lat_word", ins_word, 16'h2123);
        check("lat_level0", level, 0);
        cycle(0, 16'h0, 0, 0, 0);
        cycle(0, 16'h0, 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);

        // Fill to full, fifth word refused
        cycle(0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'h1000 + 16'(i), 0, 0, 0);
            if (i == 4) begin
                check("full_ready", in_ready, 0);
                check("full_level", level, 4);
            end
        end
        cycle(0, 16'h0, 0, 0, 0);
        check("full_level_hold", level, 4);

        // Flush with a same-cycle push and a pending issue condition
        cycle(0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 16'h5000 + 16'(i), 0, 0, 0);
        cycle(1, 16'hBEEF, 1, 1, 0);
        check("flush_ready", in_ready, 0);
        cycle(0, 16'h0, 1, 0, 0);
        check("flush_level", level, 0);
        check("flush_no_issue", new_ins, 0);
        cycle(0, 16'h0, 1, 0, 0);
        check("flush_no_issue2", new_ins, 0);

        // EXEC completion handshake, then back-to-back next issue
        cycle(0, 16'h0, 1, 0, 1);
        cycle(1, 16'h3456, 1, 0, 0);
        cycle(1, 16'h4567, 1, 0, 0);
        for (int k = 2; k <= 11; k++) begin
            cycle(0, 16'h0, (k >= 5 && k <= 8) ? 1'b0 : 1'b1, 0, 0);
            if (k == 2) check("exec_first_word", ins_word, 16'h3456);
            if (k <= 9) check("exec_busy", busy, 1);
            if (k == 10) check("exec_done_busy", busy, 0);
            if (k == 11) begin
                check("exec_next_new_ins", new_ins, 1);
                check("exec_next_word", ins_word, 16'h4567);
            end
        end

`ifdef INS_WDOG_EN
        // Core never completes: watchdog expires and the error sticks
        cycle(0, 16'h0, 1, 0, 1);
        cycle(1, 16'h6001, 1, 0, 0);
        for (int k = 1; k <= 16; k++) cycle(0, 16'h0, (k <= 2) ? 1'b1 : 1'b0, 0, 0);
        check("wdog_set", wdog_err, 1);
        check("wdog_idle", busy, 0);
        cycle(1, 16'h6002, 1, 0, 0);
        for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1, 0, 0);
        check("wdog_sticky", wdog_err, 1);
        cycle(0, 16'h0, 1, 0, 1);
        cycle(0, 16'h0, 1, 0, 0);
        check("wdog_cleared", wdog_err, 0);
`endif

        // Random traffic
        cycle(0, 16'h0, 1, 0, 1);
        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 3) != 0,
                  16'($urandom_range(0, 65535)),
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 299) == 0);
        end
        cycle(0, 16'h0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ins_issue_ctrl.md
INS_ISSUE_CTRL -- requirements
Module: ins_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction FIFO entries (power of two, 2..16).
REQ-002 Parameter WDOG_MAX, default 8'd255, meaning watchdog limit in cycles (used only under INS_WDOG_EN).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers in_word.
REQ-006 in_word  input  16  instruction word; opcode = in_word[15:12].
REQ-007 in_ready  output  1  FIFO can accept; equals !full && !flush.
REQ-008 core_wait  input  1  core FSM is in its wait state.
REQ-009 flush  input  1  discard all queued, not-yet-issued words (taken BRANCH).
REQ-010 new_ins  output  1  one-cycle issue strobe to the core.
REQ-011 ins  output  4  opcode of the issued word, held until the next issue.
REQ-012 ins_word  output  16  full issued word, held until the next issue.
REQ-013 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 busy  output  1  high in ISSUE or EXEC.
REQ-015 wdog_err  output  1  sticky watchdog error flag (tied 0 without INS_WDOG_EN).

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs on an issue; a push and a pop in the same cycle leave level unchanged.
REQ-017 When full, in_ready is 0 even if a pop occurs in the same cycle (no pass-through).
REQ-018 FSM states: IDLE, ISSUE, EXEC.
REQ-019 IDLE -> ISSUE when level>0 && core_wait && !flush; in that cycle pop the head, register ins/ins_word, and assert new_ins in the next cycle.
REQ-020 ISSUE lasts exactly one cycle with new_ins=1, then goes to EXEC.
REQ-021 EXEC -> IDLE on the first cycle core_wait is 0 and is then observed 1 again (falling edge, then return); EXEC ignores core_wait=1 before the falling edge.
REQ-022 Minimum latency: a word pushed in cycle N into an empty FIFO with the core idle gives new_ins in cycle N+2.
REQ-023 flush clears level to 0 in the next cycle, and a push in the same cycle is refused; the in-flight instruction (ISSUE/EXEC) is unaffected.
REQ-024 flush and an IDLE issue condition in the same cycle: flush wins, no issue.
REQ-025 Read and write pointers wrap modulo DEPTH.

Reset
REQ-026 Reset gives: state IDLE, level 0, pointers 0, new_ins 0, ins 0, ins_word 0, busy 0, wdog_err 0, watchdog count 0.
REQ-027 Reset mid-EXEC abandons the instruction without re-issue; reset dominates flush and push.

Configuration
REQ-028 Macro INS_WDOG_EN defined: an 8-bit counter runs in EXEC; on reaching WDOG_MAX it sets wdog_err, forces IDLE, and clears to 0 on each ISSUE.
REQ-029 INS_WDOG_EN undefined: no counter, EXEC waits indefinitely, and wdog_err is constant 0.

Structure
REQ-030 Shared package risc_pkg holds the opcode constants (LOAD..MINALL, 4'b0000..4'b0111) and the issue FSM state encoding.
REQ-031 The FIFO storage and pointers form one sub-module, ins_fifo; the FSM and watchdog stay in ins_issue_ctrl.

Verification
REQ-032 Reset, then push 16'h2123 with core_wait=1 -> new_ins at push+2, ins=4'h2, ins_word=16'h2123, level back to 0.
REQ-033 Push 5 words back-to-back with core_wait=0 -> first 4 accepted, in_ready=0 on the 5th, level=4.
REQ-034 With level=3, assert flush while a push is in the same cycle -> level=0 next cycle, push refused, no new_ins.
REQ-035 Issue, hold core_wait=1 for 3 cycles, then 0 for 4, then 1 -> busy=1 throughout, back to IDLE, next word issued one cycle later.
REQ-036 INS_WDOG_EN, WDOG_MAX=8'd10, core_wait stuck 0 after issue -> wdog_err=1 after 10 EXEC cycles, state IDLE, and wdog_err stays 1 until reset.
